// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Groups the fetch stage's control, instruction-memory and decode-handshake
// signals.
//   start      : one-cycle pulse that begins fetching
//   pc         : address to the instruction memory
//   res_ins    : instruction returned combinationally for pc
//   ir         : registered instruction presented downstream
//   ir_valid   : ir holds an instruction not yet accepted
//   dec_ready  : downstream accepts ir this cycle
//   halted     : fetch stopped on a reserved opcode
//   issue_cnt  : saturating count of accepted instructions
// master = fetch unit side, slave = memory/decode/control side.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int PC_W  = 4,
  parameter int INS_W = 9,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PC_W-1:0]  pc;
  logic [INS_W-1:0] res_ins;
  logic [INS_W-1:0] ir;
  logic             ir_valid;
  logic             dec_ready;
  logic             halted;
  logic [CNT_W-1:0] issue_cnt;

  modport master (
    input  start, res_ins, dec_ready,
    output pc, ir, ir_valid, halted, issue_cnt
  );

  modport slave (
    output start, res_ins, dec_ready,
    input  pc, ir, ir_valid, halted, issue_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage owning the program counter. Drives pc to the
// instruction memory, captures the returned word into the IR and offers it
// downstream on a valid/ready handshake. A word with its top bit set is a
// reserved opcode: it is never issued and the unit halts with pc left on it.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : fetch_unit_if master modport (see interface header)
// Parameters must match those of the connected interface.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_W  = 4,
  parameter int INS_W = 9,
  parameter int CNT_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);

  localparam logic [INS_W-1:0] NOOP = INS_W'(9'h0C0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;
  logic             load;

  assign xfer = ir_valid_q & bus.dec_ready;
  assign load = ~ir_valid_q | bus.dec_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;

    // Acceptance is independent of state so a pending IR drains in HALT too.
    if (xfer) begin
      ir_valid_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The halt word is recognised as soon as pc points at it, even while
        // a stalled IR is still waiting; pc stays on the halt word.
        if (bus.res_ins[INS_W-1]) begin
          state_d = HALT;
        end else if (load) begin
          ir_d       = bus.res_ins;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 1'b1;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= NOOP;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.halted    = (state_q == HALT);
  assign bus.issue_cnt = cnt_q;

endmodule
